// File: rtl/minmax_sequencer_if.sv
// Sample handshake between a producer and the min/max tracker.
interface minmax_sequencer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/minmax_sequencer.sv
// Streaming min/max tracker for unsigned 16-bit samples. One magnitude
// comparator is shared in time: a new sample is compared against the running
// maximum in CMP_MAX and then against the running minimum in CMP_MIN. The
// first sample after reset/clear bypasses the comparator.
module minmax_sequencer #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  minmax_sequencer_if.slave    smp,
  output logic [15:0]          max_val,
  output logic [15:0]          min_val,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic                 update_done,
  output logic                 count_sat
);

  localparam int DATA_W = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMP_MAX = 2'd1,
    CMP_MIN = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   hold;
  logic [DATA_W-1:0]   cmp_a;
  logic [DATA_W-1:0]   cmp_b;
  logic                cmp_gt;
  logic                cmp_lt;
  logic                ready;
  logic                xfer;

  // Saturating increment of the accepted-sample counter.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    if (c == CNT_MAX) begin
      return c;
    end
    return c + CNT_WIDTH'(1);
  endfunction

  assign ready            = (state == IDLE) && !clear;
  assign smp.sample_ready = ready;
  assign xfer             = smp.sample_valid && ready;

  // Shared comparator: operand selection depends on state only; in IDLE the
  // operands default to the CMP_MAX pairing and the result is ignored.
  always_comb begin
    cmp_a = hold;
    cmp_b = max_val;
    if (state == CMP_MIN) begin
      cmp_b = min_val;
    end
  end

  assign cmp_gt = cmp_a > cmp_b;
  assign cmp_lt = cmp_a < cmp_b;

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clear always returns to IDLE, discarding any in-flight sample.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (xfer && (sample_count != '0)) begin
            state_nxt = CMP_MAX;
          end
        end
        CMP_MAX: state_nxt = CMP_MIN;
        CMP_MIN: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Statistics, held sample and the update_done pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold         <= '0;
      max_val      <= '0;
      min_val      <= '0;
      sample_count <= '0;
      update_done  <= 1'b0;
      count_sat    <= 1'b0;
    end else if (clear) begin
      max_val      <= '0;
      min_val      <= '0;
      sample_count <= '0;
      update_done  <= 1'b0;
      count_sat    <= 1'b0;
    end else begin
      update_done <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (sample_count == '0) begin
              max_val      <= smp.sample;
              min_val      <= smp.sample;
              sample_count <= CNT_WIDTH'(1);
              update_done  <= 1'b1;
            end else begin
              hold <= smp.sample;
            end
          end
        end
        CMP_MAX: begin
          if (cmp_gt) begin
            max_val <= hold;
          end
        end
        CMP_MIN: begin
          if (cmp_lt) begin
            min_val <= hold;
          end
          if (sample_count == CNT_MAX) begin
            count_sat <= 1'b1;
          end
          sample_count <= sat_inc(sample_count);
          update_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_sequencer.sv
// Directed bench for minmax_sequencer with a scoreboard of expected
// statistics checked on every update_done pulse.
module tb_minmax_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst;
  logic        clear;
  logic        clear2;
  logic [15:0] max_val, min_val, max2, min2;
  logic [7:0]  sample_count;
  logic [1:0]  count2;
  logic        update_done, count_sat, done2, sat2;

  minmax_sequencer_if bus ();
  minmax_sequencer_if bus2 ();

  minmax_sequencer #(.CNT_WIDTH(8)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .smp          (bus.slave),
    .max_val      (max_val),
    .min_val      (min_val),
    .sample_count (sample_count),
    .update_done  (update_done),
    .count_sat    (count_sat)
  );

  minmax_sequencer #(.CNT_WIDTH(2)) dut2 (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear2),
    .smp          (bus2.slave),
    .max_val      (max2),
    .min_val      (min2),
    .sample_count (count2),
    .update_done  (done2),
    .count_sat    (sat2)
  );

  typedef struct packed {
    logic [15:0] mx;
    logic [15:0] mn;
    logic [7:0]  cnt;
    logic        sat;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] m_max = '0;
  logic [15:0] m_min = '0;
  logic [7:0]  m_cnt = '0;
  logic        m_sat = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush_model();
    sb.delete();
    m_max = '0;
    m_min = '0;
    m_cnt = '0;
    m_sat = 1'b0;
  endtask

  // Drive one sample; returns 1 time unit after the transfer edge.
  task automatic send(input logic [15:0] v);
    int n = 0;
    bus.sample       = v;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    while (!bus.sample_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", bus.sample_ready, 1);
    if (m_cnt == 0) begin
      m_max = v;
      m_min = v;
      m_cnt = 8'd1;
    end else begin
      if (v > m_max) m_max = v;
      if (v < m_min) m_min = v;
      if (m_cnt == 8'hFF) m_sat = 1'b1;
      else m_cnt++;
    end
    sb.push_back('{m_max, m_min, m_cnt, m_sat});
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  // Non-first sample with the two-cycle busy window checked.
  task automatic send_lat(input logic [15:0] v);
    send(v);
    chk("busy_k1", bus.sample_ready, 0);
    tick();
    chk("busy_k2", bus.sample_ready, 0);
    tick();
    chk("ready_k3", bus.sample_ready, 1);
    chk("done_k2", update_done, 1);
  endtask

  task automatic send2(input logic [15:0] v);
    int n = 0;
    bus2.sample       = v;
    bus2.sample_valid = 1'b1;
    @(negedge clk);
    while (!bus2.sample_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus2.sample_valid = 1'b0;
    n = 0;
    while (!done2 && n < 10) begin
      tick();
      n++;
    end
    chk("sat_done", done2, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_max"}, max_val, 0);
    chk({tag, "_min"}, min_val, 0);
    chk({tag, "_cnt"}, sample_count, 0);
    chk({tag, "_done"}, update_done, 0);
    chk({tag, "_sat"}, count_sat, 0);
  endtask

  // Scoreboard: every update_done must match the oldest pending expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (update_done) begin
      chk("done_has_pending", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_max", max_val, e.mx);
        chk("sb_min", min_val, e.mn);
        chk("sb_cnt", sample_count, e.cnt);
        chk("sb_sat", count_sat, e.sat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] vals2 [4];
    logic [1:0]  cnt2_exp [4];
    vals2    = '{16'd5, 16'd9, 16'd1, 16'd9};
    cnt2_exp = '{2'd1, 2'd2, 2'd3, 2'd3};

    n_rst             = 1'b0;
    clear             = 1'b0;
    clear2            = 1'b0;
    bus.sample        = '0;
    bus.sample_valid  = 1'b0;
    bus2.sample       = '0;
    bus2.sample_valid = 1'b0;
    tick(2);
    chk_reset_vals("rst");
    chk("rst_ready", bus.sample_ready, 1);
    n_rst = 1'b1;
    tick();

    // 100, 50, 200, 50
    send(16'd100);
    chk("first_max", max_val, 100);
    chk("first_min", min_val, 100);
    chk("first_cnt", sample_count, 1);
    chk("first_done", update_done, 1);
    send_lat(16'd50);
    send_lat(16'd200);
    send_lat(16'd50);
    chk("seq_max", max_val, 200);
    chk("seq_min", min_val, 50);
    chk("seq_cnt", sample_count, 4);

    // Async reset, then 8000 twice
    n_rst = 1'b0;
    #1;
    chk_reset_vals("rst2");
    flush_model();
    tick();
    n_rst = 1'b1;
    send(16'h8000);
    chk("h8000_max", max_val, 16'h8000);
    chk("h8000_min", min_val, 16'h8000);
    chk("h8000_cnt", sample_count, 1);
    chk("h8000_done", update_done, 1);
    tick();
    chk("done_pulse", update_done, 0);
    send_lat(16'h8000);
    chk("eq_max", max_val, 16'h8000);
    chk("eq_min", min_val, 16'h8000);
    chk("eq_cnt", sample_count, 2);

    // 0 then FFFF with per-edge latency
    send_lat(16'h0000);
    chk("zero_min", min_val, 0);
    send(16'hFFFF);
    chk("ffff_k0_max", max_val, 16'h8000);
    tick();
    chk("ffff_k1_max", max_val, 16'hFFFF);
    chk("ffff_k1_cnt", sample_count, 3);
    tick();
    chk("ffff_k2_min", min_val, 0);
    chk("ffff_k2_cnt", sample_count, 4);
    chk("ffff_k2_done", update_done, 1);

    // Clear during CMP_MAX discards the in-flight sample
    clear = 1'b1;
    tick();
    clear = 1'b0;
    flush_model();
    send(16'd200);
    send(16'd300);
    clear            = 1'b1;
    bus.sample       = 16'd999;
    bus.sample_valid = 1'b1;
    #1;
    chk("clr_ready", bus.sample_ready, 0);
    @(posedge clk);
    #1;
    clear            = 1'b0;
    bus.sample_valid = 1'b0;
    flush_model();
    chk_reset_vals("clr");
    tick(3);
    chk("clr_no_xfer_cnt", sample_count, 0);
    chk("clr_max_after", max_val, 0);
    send(16'd7);
    chk("post_clr_max", max_val, 7);
    chk("post_clr_min", min_val, 7);
    chk("post_clr_cnt", sample_count, 1);

    // Saturating counter on the 2-bit instance
    for (int i = 0; i < 4; i++) begin
      send2(vals2[i]);
      chk("sat_cnt", count2, cnt2_exp[i]);
      chk("sat_flag", sat2, (i == 3) ? 1 : 0);
    end
    chk("sat_max", max2, 9);
    chk("sat_min", min2, 1);
    clear2 = 1'b1;
    tick();
    clear2 = 1'b0;
    chk("sat_clr_flag", sat2, 0);
    chk("sat_clr_cnt", count2, 0);

    // Async reset during CMP_MIN
    send(16'd10);
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    chk("midrst_ready", bus.sample_ready, 1);
    flush_model();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    chk("rel_ready", bus.sample_ready, 1);
    send(16'd55);
    chk("rel_max", max_val, 55);
    chk("rel_min", min_val, 55);
    chk("rel_cnt", sample_count, 1);
    chk("rel_done", update_done, 1);

    tick(3);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/minmax_sequencer.md
Name: minmax_sequencer

Overview:
- Streaming min/max tracker for unsigned 16-bit samples.
- Time-multiplexes a single instance of the team's 16-bit comparator (a, b -> gt, lt, eq). Compares each accepted sample first against the running maximum, then against the running minimum.
- Sits between a sample producer (valid/ready) and status logic that reads max_val, min_val and sample_count.

Parameters:
- CNT_WIDTH, 8, width of the accepted-sample counter; the counter saturates at 2^CNT_WIDTH-1.

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of tracked statistics; highest priority after reset.
- sample  input  16  unsigned sample data.
- sample_valid  input  1  producer asserts when sample is valid.
- sample_ready  output  1  block can accept a sample this cycle.
- max_val  output  16  running maximum (registered).
- min_val  output  16  running minimum (registered).
- sample_count  output  CNT_WIDTH  number of samples accepted since reset/clear (registered, saturating).
- update_done  output  1  one-cycle pulse: max/min/count reflect the latest sample.
- count_sat  output  1  sticky; set when an accepted sample arrives with sample_count already at maximum.

Behaviour:
- Reset (n_rst low, async): state=IDLE, hold=0, max_val=0, min_val=0, sample_count=0, update_done=0, count_sat=0.
- sample_ready = (state==IDLE) && !clear, combinational. A transfer occurs on a rising edge with sample_valid && sample_ready. sample must be held stable while valid && !ready.
- FSM states: IDLE, CMP_MAX, CMP_MIN.
- IDLE, transfer with sample_count==0:
  - max_val, min_val <= sample; sample_count <= 1; update_done=1 next cycle.
  - Stay in IDLE (first-sample bypass, no comparator use).
- IDLE, transfer with sample_count!=0:
  - hold <= sample; go to CMP_MAX.
- CMP_MAX:
  - Comparator a=hold, b=max_val.
  - If gt: max_val <= hold. eq or lt: no change.
  - Go to CMP_MIN.
- CMP_MIN:
  - Comparator a=hold, b=min_val.
  - If lt: min_val <= hold. eq or gt: no change.
  - sample_count <= sample_count+1 unless at max. If at max, it holds and count_sat <= 1.
  - update_done <= 1; go to IDLE.
- Comparator operand muxes are driven only by state. In IDLE the operands are a=hold, b=max_val, and the outputs are ignored.
- Latency for a non-first sample accepted at edge k:
  - max_val updates at edge k+1.
  - min_val and sample_count update at edge k+2.
  - update_done is high for the cycle after edge k+2.
  - Throughput: one sample per 3 cycles.
  - First sample: all updates at edge k; update_done high the following cycle.
- update_done is a single-cycle pulse; it is deasserted on every other cycle.
- Because update_done is registered, the block is in IDLE and ready while update_done is high, so back-to-back acceptance is allowed.
- clear asserted, any state:
  - Next edge: state=IDLE, max_val=0, min_val=0, sample_count=0, count_sat=0, update_done=0.
  - An in-flight sample (CMP_MAX/CMP_MIN) is discarded with no update_done.
  - clear with sample_valid in the same cycle: no transfer (ready is low).
- Equal samples leave max/min unchanged but still increment the count.
- A sample of 0 or 16'hFFFF needs no special casing; the unsigned compare handles both.
- Async reset mid-operation aborts immediately to the reset values.

Test Plan:
- Reset, then samples 100, 50, 200, 50 with valid held high -> after the final update_done: max_val=200, min_val=50, sample_count=4. sample_ready low exactly 2 cycles after each non-first transfer.
- First sample 16'h8000 after reset -> same-edge max_val=min_val=16'h8000, count=1, update_done pulse next cycle. Second sample 16'h8000 -> max/min unchanged, count=2.
- Samples 16'h0000 then 16'hFFFF -> min_val=0, max_val=16'hFFFF. Verify max changes at k+1 and min is unchanged at k+2.
- Accept sample 300 after max=200; assert clear during CMP_MAX -> no update_done, all outputs 0 next edge. Next sample 7 -> max=min=7, count=1.
- CNT_WIDTH=2: accept 4 samples -> sample_count=3 and count_sat=1 on the 4th. Clear -> count_sat=0.
- Assert n_rst low during CMP_MIN -> outputs return to reset values immediately and asynchronously. After release, sample_ready=1 and the next sample is treated as first.
